// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Bundles everything that crosses the arbiter boundary apart from clock
// and reset: the two requester handshakes and the data-memory bus.
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : requester -> arbiter
//   ack0/ack1, rdata0/rdata1, err0/err1             : arbiter -> requester
//   busy                                            : arbiter status
//   mem_rd, mem_wr, mem_addr, mem_wdata             : arbiter -> memory
//   mem_rdata                                       : memory -> arbiter
// The slave modport is the arbiter's view. The master modport is the view
// of whatever surrounds it: the requesters and the memory.
interface dmem_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        ack0;
    logic        ack1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic        err0;
    logic        err1;
    logic        busy;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata0, rdata1, err0, err1, busy,
               mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata0, rdata1, err0, err1, busy,
               mem_rd, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one byte-addressed, big-endian, word-wide data memory between
// requester 0 (CPU load/store) and requester 1 (debug/DMA loader).
// Requesters are granted in round-robin order. Every access runs as a
// fixed IDLE -> ACCESS -> RESP transaction. Misaligned and out-of-range
// addresses are rejected before they reach the memory.
// Ports:
//   CLK  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : dmem_arbiter_if.slave (requester handshakes and memory bus)
// Parameter:
//   MEM_BYTES : memory size in bytes; a word at addr is legal if addr+3 < MEM_BYTES
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 32
) (
    input  logic           CLK,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Highest legal word address. The compare is unsigned, so a wrapping
    // address like 0xFFFFFFFC is treated as out of range.
    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    state_t      state;
    state_t      state_next;

    logic        last_grant;
    logic        grant;
    logic        lat_we;
    logic        lat_bad;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] resp_data;

    logic        win;
    logic        win_we;
    logic        win_bad;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;

    // Round-robin pick. On a tie the port that did not win last time gets
    // the grant. The winner's address is checked here, so the transaction
    // carries a ready-made error flag through ACCESS and RESP.
    always_comb begin
        win       = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
        win_we    = win ? bus.we1    : bus.we0;
        win_addr  = win ? bus.addr1  : bus.addr0;
        win_wdata = win ? bus.wdata1 : bus.wdata0;
        win_bad   = (win_addr[1:0] != 2'b00) || (win_addr > LAST_WORD);
    end

    // State register. Reset clears it asynchronously, so the decoded
    // memory strobes fall as soon as reset rises. A write that has not
    // reached its clock edge is aborted and never acknowledged.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode. Outputs depend only on the state and
    // the latched transaction, never on live request inputs. This keeps
    // the memory bus and the acks free of paths from req/addr. A rejected
    // access drives no strobe and leaves mem_addr/mem_wdata at zero, so a
    // bad write can never touch the memory.
    always_comb begin
        state_next    = state;
        bus.busy      = 1'b0;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.ack0      = 1'b0;
        bus.ack1      = 1'b0;
        bus.err0      = 1'b0;
        bus.err1      = 1'b0;
        bus.rdata0    = 32'h0;
        bus.rdata1    = 32'h0;

        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                bus.busy = 1'b1;
                if (!lat_bad) begin
                    bus.mem_addr = lat_addr;
                    if (lat_we) begin
                        bus.mem_wr    = 1'b1;
                        bus.mem_wdata = lat_wdata;
                    end else begin
                        bus.mem_rd = 1'b1;
                    end
                end
                state_next = RESP;
            end
            RESP: begin
                bus.busy = 1'b1;
                if (grant) begin
                    bus.ack1   = 1'b1;
                    bus.err1   = lat_bad;
                    bus.rdata1 = resp_data;
                end else begin
                    bus.ack0   = 1'b1;
                    bus.err0   = lat_bad;
                    bus.rdata0 = resp_data;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Transaction latch and response register. The winner's request is
    // captured when leaving IDLE. The memory's combinational read data is
    // registered at the edge that ends ACCESS. last_grant resets to port 1
    // so that port 0 wins the first tie after reset.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            grant      <= 1'b0;
            lat_we     <= 1'b0;
            lat_bad    <= 1'b0;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            resp_data  <= 32'h0;
        end else begin
            if (state == IDLE && (bus.req0 || bus.req1)) begin
                grant      <= win;
                last_grant <= win;
                lat_we     <= win_we;
                lat_bad    <= win_bad;
                lat_addr   <= win_addr;
                lat_wdata  <= win_wdata;
            end
            if (state == ACCESS) begin
                resp_data <= (lat_bad || lat_we) ? 32'h0 : bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed bench for dmem_arbiter. It models a 32-byte big-endian memory
// preloaded with byte i = 0x40 + i, and drives both requesters through
// the interface master view.
module tb_dmem_arbiter;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.MEM_BYTES(32)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-unit clock.
    always #5 CLK = ~CLK;

    logic [7:0] mem [0:31];
    logic [4:0] ra;
    int assert_count = 0;
    int fail_count   = 0;
    int cyc          = 0;
    int ack0_count   = 0;
    int ack1_count   = 0;
    int wr_cycles    = 0;

    // Combinational big-endian read port of the memory model.
    assign ra = bus.mem_addr[4:0];
    assign bus.mem_rdata = bus.mem_rd ?
        {mem[ra], mem[ra + 5'd1], mem[ra + 5'd2], mem[ra + 5'd3]} : 32'h0;

    // Memory model. It loads a known pattern while preload is high.
    // After that it stores a big-endian word on each edge that has
    // mem_wr high.
    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'(8'h40 + i);
        end else if (bus.mem_wr) begin
            mem[bus.mem_addr[4:0]]        <= bus.mem_wdata[31:24];
            mem[bus.mem_addr[4:0] + 5'd1] <= bus.mem_wdata[23:16];
            mem[bus.mem_addr[4:0] + 5'd2] <= bus.mem_wdata[15:8];
            mem[bus.mem_addr[4:0] + 5'd3] <= bus.mem_wdata[7:0];
        end
    end

    // Pulse counters, sampled mid-cycle away from the active edge.
    always @(negedge CLK) begin
        if (bus.ack0) ack0_count++;
        if (bus.ack1) ack1_count++;
        if (bus.mem_wr) wr_cycles++;
    end

    // Watchdog so the run can never hang.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] peek(input int a);
        return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkFlag(input string tag, input logic obs, input logic exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end else begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkFlag({tag, ".busy"}, bus.busy, 1'b0);
        checkFlag({tag, ".mem_rd"}, bus.mem_rd, 1'b0);
        checkFlag({tag, ".mem_wr"}, bus.mem_wr, 1'b0);
        checkOutput({tag, ".mem_addr"}, bus.mem_addr, 32'h0);
        checkOutput({tag, ".mem_wdata"}, bus.mem_wdata, 32'h0);
        checkFlag({tag, ".ack0"}, bus.ack0, 1'b0);
        checkFlag({tag, ".ack1"}, bus.ack1, 1'b0);
        checkFlag({tag, ".err0"}, bus.err0, 1'b0);
        checkFlag({tag, ".err1"}, bus.err1, 1'b0);
        checkOutput({tag, ".rdata0"}, bus.rdata0, 32'h0);
        checkOutput({tag, ".rdata1"}, bus.rdata1, 32'h0);
    endtask

    // One isolated transaction. The request is raised in IDLE. The next
    // cycle must be ACCESS, and the one after it must carry the ack.
    task automatic doTxn(input string tag, input int port, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata);
        int wr_before;
        logic good;
        wr_before = wr_cycles;
        good = !exp_err;
        applyStimulus(port, 1'b1, we, addr, wdata);
        tick();
        checkFlag({tag, ".acc.busy"}, bus.busy, 1'b1);
        checkFlag({tag, ".acc.mem_wr"}, bus.mem_wr, we && good);
        checkFlag({tag, ".acc.mem_rd"}, bus.mem_rd, !we && good);
        checkOutput({tag, ".acc.mem_addr"}, bus.mem_addr, good ? addr : 32'h0);
        checkOutput({tag, ".acc.mem_wdata"}, bus.mem_wdata, (good && we) ? wdata : 32'h0);
        checkFlag({tag, ".acc.ack"}, bus.ack0 | bus.ack1, 1'b0);
        tick();
        checkFlag({tag, ".resp.ack0"}, bus.ack0, port == 0);
        checkFlag({tag, ".resp.ack1"}, bus.ack1, port == 1);
        checkFlag({tag, ".resp.err"}, port == 0 ? bus.err0 : bus.err1, exp_err);
        checkOutput({tag, ".resp.rdata"}, port == 0 ? bus.rdata0 : bus.rdata1, exp_rdata);
        checkOutput({tag, ".resp.other_rdata"}, port == 0 ? bus.rdata1 : bus.rdata0, 32'h0);
        checkFlag({tag, ".resp.mem_wr"}, bus.mem_wr, 1'b0);
        applyStimulus(port, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkFlag({tag, ".idle.busy"}, bus.busy, 1'b0);
        checkOutput({tag, ".wr_cycles"}, 32'(wr_cycles - wr_before), (we && good) ? 32'd1 : 32'd0);
    endtask

    logic [31:0] b2b_addr [4] = '{32'd0, 32'd4, 32'd8, 32'd12};
    logic [31:0] b2b_data [4] = '{32'h40414243, 32'h44454647, 32'h11223344, 32'h4C4D4E4F};

    initial begin
        int waited;
        int prev_cyc;
        int ack_before;
        int wr_before;

        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        preload = 1'b0;
        checkAllZero("reset");
        rst = 1'b0;
        tick();
        checkAllZero("post_reset");

        // Write then read back at address 8.
        doTxn("wr8", 0, 1'b1, 32'd8, 32'h11223344, 1'b0, 32'h0);
        checkOutput("mem8_bytes", peek(8), 32'h11223344);
        doTxn("rd8", 0, 1'b0, 32'd8, 32'h0, 1'b0, 32'h11223344);

        // Rejected write and the address-range boundaries.
        doTxn("wr6_bad", 0, 1'b1, 32'd6, 32'hCAFEF00D, 1'b1, 32'h0);
        checkOutput("mem4_unchanged", peek(4), 32'h44454647);
        checkOutput("mem8_unchanged", peek(8), 32'h11223344);
        doTxn("rd28", 1, 1'b0, 32'd28, 32'h0, 1'b0, 32'h5C5D5E5F);
        doTxn("rd29_bad", 0, 1'b0, 32'd29, 32'h0, 1'b1, 32'h0);
        doTxn("rd_wrap_bad", 1, 1'b0, 32'hFFFFFFFE, 32'h0, 1'b1, 32'h0);
        doTxn("rd32_bad", 0, 1'b0, 32'd32, 32'h0, 1'b1, 32'h0);

        // Tie after reset: grant order 0,1,0,1 with acks 3 cycles apart.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 32'd0, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'd4, 32'h0);
        prev_cyc = cyc;
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            while (!(bus.ack0 || bus.ack1) && waited < 8) begin
                tick();
                waited++;
            end
            checkFlag($sformatf("tie%0d.timeout", k), waited < 8, 1'b1);
            checkFlag($sformatf("tie%0d.ack0", k), bus.ack0, (k % 2) == 0);
            checkFlag($sformatf("tie%0d.ack1", k), bus.ack1, (k % 2) == 1);
            checkOutput($sformatf("tie%0d.rdata", k),
                        (k % 2 == 0) ? bus.rdata0 : bus.rdata1,
                        (k % 2 == 0) ? 32'h40414243 : 32'h44454647);
            if (k > 0) checkOutput($sformatf("tie%0d.spacing", k), 32'(cyc - prev_cyc), 32'd3);
            else checkOutput("tie0.latency", 32'(cyc - prev_cyc), 32'd2);
            prev_cyc = cyc;
            if (k == 3) begin
                applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
                applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            tick();
        end
        checkFlag("tie.idle_busy", bus.busy, 1'b0);

        // Back-to-back reads from port 1 with req1 held high.
        ack_before = ack0_count;
        applyStimulus(1, 1'b1, 1'b0, b2b_addr[0], 32'h0);
        prev_cyc = cyc;
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            while (!bus.ack1 && waited < 8) begin
                tick();
                waited++;
            end
            checkFlag($sformatf("b2b%0d.timeout", k), waited < 8, 1'b1);
            checkOutput($sformatf("b2b%0d.rdata1", k), bus.rdata1, b2b_data[k]);
            checkFlag($sformatf("b2b%0d.err1", k), bus.err1, 1'b0);
            checkOutput($sformatf("b2b%0d.spacing", k), 32'(cyc - prev_cyc), (k == 0) ? 32'd2 : 32'd3);
            prev_cyc = cyc;
            if (k < 3) applyStimulus(1, 1'b1, 1'b0, b2b_addr[k + 1], 32'h0);
            else applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
            tick();
        end
        checkOutput("b2b.no_ack0", 32'(ack0_count - ack_before), 32'd0);

        // Reset in the middle of ACCESS for a write to 16.
        ack_before = ack0_count;
        wr_before = wr_cycles;
        applyStimulus(0, 1'b1, 1'b1, 32'd16, 32'hDEADBEEF);
        tick();
        checkFlag("rstmid.mem_wr_before", bus.mem_wr, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("rstmid");
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("rstmid.no_ack", 32'(ack0_count - ack_before), 32'd0);
        checkOutput("rstmid.no_write", 32'(wr_cycles - wr_before), 32'd0);
        checkOutput("rstmid.mem16", peek(16), 32'h50515253);

        // Idle stability for 20 cycles with no request.
        for (int i = 0; i < 20; i++) begin
            tick();
            checkFlag("idle.busy", bus.busy, 1'b0);
            checkFlag("idle.mem_rd", bus.mem_rd, 1'b0);
            checkFlag("idle.mem_wr", bus.mem_wr, 1'b0);
            checkOutput("idle.mem_addr", bus.mem_addr, 32'h0);
            checkOutput("idle.mem_wdata", bus.mem_wdata, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
